// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and data (D) requesters.
// Define RR_ARB_EN to break simultaneous IDLE requests in favour of the requester that was not acked last.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               win_d, win_d_n;
  logic               last_d, last_d_n;
  logic               mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [DATA_W-1:0]  mem_wdata_n;
  logic [DATA_W-1:0]  i_rdata_n, d_rdata_n;
  logic               i_ack_n, d_ack_n, busy_n;
  logic               grant, grant_d, both_pick_d;

  // State and every output live in this one register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
      last_d    <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      win_d     <= win_d_n;
      last_d    <= last_d_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      i_ack     <= i_ack_n;
      d_ack     <= d_ack_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic; the registered outputs take these values one edge later.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    win_d_n     = win_d;
    last_d_n    = last_d;
    mem_en_n    = 1'b0;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    i_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    grant       = 1'b0;
    grant_d     = 1'b0;
`ifdef RR_ARB_EN
    both_pick_d = !last_d;
`else
    both_pick_d = 1'b1;
`endif

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          grant_d = d_req && (!i_req || both_pick_d);
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_n  = RESP;
          last_d_n = win_d;
          if (win_d) begin
            d_ack_n = 1'b1;
            if (!mem_we) d_rdata_n = mem_rdata;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = mem_rdata;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        // The just-acked requester still shows its old request; only the other one may take over.
        if (win_d ? i_req : d_req) begin
          grant   = 1'b1;
          grant_d = !win_d;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant) begin
      state_n    = ISSUE;
      win_d_n    = grant_d;
      mem_en_n   = 1'b1;
      mem_we_n   = grant_d && d_we;
      mem_addr_n = grant_d ? d_addr : i_addr;
      if (grant_d) mem_wdata_n = d_wdata;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (I) and the data-access requester (D) of the 5-stage core.
- Used in the unified-memory build variant, which replaces the separate imem/dmem pair.
- Serialises accesses through a sequencing FSM and returns per-requester acks, which the hazard unit turns into stall_f and stall at the MEM stage.
- Only one access is in flight at a time.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LAT, 1, cycles from the memory sampling mem_en to mem_rdata being valid. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch byte address; stable while i_req is high.
- i_rdata  out  DATA_W  fetched word; registered, valid while i_ack is high.
- i_ack  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; registered.
- d_ack  out  1  one-cycle completion pulse for D.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address; passed through unmodified.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: clk and reset as above, reset asynchronous active-high. All outputs are 0 while reset is high; state = IDLE; last-owner = D.
- All outputs are driven from registers; there is no combinational path from any input to any output.

States:
- IDLE: if any request is pending, pick a winner, latch its addr/we/wdata, go to ISSUE.
- ISSUE: one cycle. mem_en=1 and mem_we=latched we; mem_addr/mem_wdata = latched values. Go to WAIT with the counter loaded to MEM_LAT.
- WAIT: decrement the counter each cycle. At the edge where the counter reaches 1, capture mem_rdata into the winner's rdata register (reads only), then go to RESP.
- RESP: one cycle; the winner's ack = 1.
  - In this cycle the acked requester's req is ignored, because it still shows the old request.
  - If the other requester's req is high, it becomes the new winner and the FSM goes directly to ISSUE; otherwise go to IDLE.

Timing:
- Arbitration in IDLE: if only one req is high, grant it. If both are high, D wins (fixed priority; see Optional Feature).
- Latency: req sampled in IDLE at cycle 0 -> mem_en in cycle 1 -> ack in cycle MEM_LAT+2.
- Hand-off from RESP saves the IDLE cycle.

Data and outputs:
- Writes: d_ack follows the same timing as reads; d_rdata is not updated.
- i_rdata/d_rdata hold their last captured value between acks.
- mem_we/mem_addr/mem_wdata hold their values outside ISSUE; mem_en is 0 outside ISSUE.

Boundary conditions:
- Requester drops req before its ack (protocol violation): the access still completes and the ack still pulses.
- Reset asserted mid-access: the FSM is abandoned immediately and no ack is issued. A write already strobed may have reached the memory; that is acceptable.
- No reordering: each ack corresponds to the single outstanding access.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: when both requests are high in IDLE, grant the requester that is not the last-owner (the last acked requester). last-owner updates on every ack.
- Undefined: fixed D priority in IDLE. The RESP hand-off rule is identical in both builds.

Test Plan:
1. MEM_LAT=1; i_req with i_addr=0x40; memory returns 0x20100005 -> mem_en=1, mem_we=0, mem_addr=0x40 in cycle 1; i_ack=1 with i_rdata=0x20100005 in cycle 3; busy high in cycles 1-3.
2. i_req(0x44) and d_req read (0x80) both raised in cycle 0 -> D issued in cycle 1, d_ack in cycle 3; I issued in cycle 4 via hand-off, i_ack in cycle 6 with mem_addr=0x44.
3. d write to 0x84 with d_wdata=0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x84, mem_wdata=0xDEADBEEF; d_ack in cycle 3; d_rdata unchanged; i_ack stays 0.
4. MEM_LAT=3 with a single d read -> mem_en in cycle 1, d_ack in cycle 5; no second mem_en pulse.
5. reset pulsed in a WAIT cycle -> all outputs 0 within the same cycle, no ack; a new i_req afterwards completes with the normal 3-cycle latency.
6. After a D access completes and the arbiter returns to IDLE, raise i_req and d_req together -> with RR_ARB_EN defined, I is granted first; without it, D is granted first.
